// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction SRAM port bundle between the fetch stage and the SRAM
interface if_stage_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_rdata
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch: PC, redirects across stalls, IF/ID word buffer
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [32:0]  br_bus,
    output logic [33:0]  if_to_id_bus,
    output logic [31:0]  if_inst,
    if_stage_if.master   inst_sram
);

    // A redirect seen while the PC is held is remembered until the hold lifts.
    typedef enum logic {
        PC_NOPEND = 1'b0,
        PC_PEND   = 1'b1
    } pc_state_e;

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        adel_q, adel_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        hold_pc;
    logic        hold_ifid;
    logic [31:0] next_pc;
    logic        stall_unused;

    assign br_e      = br_bus[32];
    assign br_addr   = br_bus[31:0];
    assign hold_pc   = stall[0];
    assign hold_ifid = stall[1];
    // Later pipeline stages own the upper stall bits; fetch ignores them.
    assign stall_unused = &{1'b0, stall[5:2]};

    // Next fetch address: live redirect beats a remembered one, which beats sequential.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (state_q == PC_PEND) begin
            next_pc = pend_addr_q;
        end
    end

    // PC advance / hold and pending-redirect capture.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ce_d        = ce_q;
        adel_d      = adel_q;
        pend_addr_d = pend_addr_q;
        if (!hold_pc) begin
            pc_d    = next_pc;
            ce_d    = 1'b1;
            adel_d  = (next_pc[1:0] != 2'b00);
            state_d = PC_NOPEND;
        end else begin
            case (state_q)
                PC_NOPEND: begin
                    if (br_e) begin
                        state_d     = PC_PEND;
                        pend_addr_d = br_addr;
                    end
                end
                PC_PEND: begin
                    if (br_e) begin
                        pend_addr_d = br_addr;
                    end
                end
                default: state_d = PC_NOPEND;
            endcase
        end
    end

    // Capture the word on the first IF/ID-held edge; SRAM data is not refetched while held.
    always_comb begin
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        if (!hold_ifid) begin
            buf_valid_d = 1'b0;
        end else if (!buf_valid_q) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = inst_sram.inst_sram_rdata;
        end
    end

    // PC state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PC_NOPEND;
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            adel_q      <= 1'b0;
            pend_addr_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            adel_q      <= adel_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Instruction buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            inst_buf_q  <= 32'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    // Misaligned PCs are presented as a nop so decode only has to look at adel.
    always_comb begin
        if_inst = inst_sram.inst_sram_rdata;
        if (adel_q) begin
            if_inst = 32'b0;
        end else if (buf_valid_q) begin
            if_inst = inst_buf_q;
        end
    end

    assign if_to_id_bus              = {adel_q, ce_q, pc_q};
    assign inst_sram.inst_sram_en    = rst & ~hold_pc & (next_pc[1:0] == 2'b00);
    assign inst_sram.inst_sram_wen   = 4'b0;
    assign inst_sram.inst_sram_addr  = next_pc;
    assign inst_sram.inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a behavioural fetch model
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = 6'b0;
    logic [32:0] br_bus = 33'b0;
    logic [33:0] if_to_id_bus;
    logic [31:0] if_inst;

    if_stage_if sram_if();

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_bus       (br_bus),
        .if_to_id_bus (if_to_id_bus),
        .if_inst      (if_inst),
        .inst_sram    (sram_if.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h1357} + 32'h0000_0101;
    endfunction

    // Synchronous SRAM; a disabled read leaves garbage on rdata.
    always @(posedge clk) begin
        if (sram_if.inst_sram_en)
            sram_if.inst_sram_rdata <= mem_word(sram_if.inst_sram_addr);
        else
            sram_if.inst_sram_rdata <= $urandom;
    end

    typedef struct {
        bit          r;
        logic [31:0] pc;
        bit          ce;
        bit          adel;
        bit          en;
        logic [31:0] addr;
        bit          chk_inst;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;

    // Reference model state: architectural PC view plus the list of redirects seen while held.
    logic [31:0] m_pc = RESET_PC;
    bit          m_ce = 1'b0;
    bit          m_adel = 1'b0;
    logic [31:0] m_pend[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // One cycle: apply inputs just after the falling edge, predict this cycle's outputs, advance model.
    task automatic step(input bit r, input bit s, input bit be, input logic [31:0] ba);
        exp_t        e;
        logic [31:0] tgt;
        rst    = r;
        stall  = {4'($urandom), s, s};
        br_bus = {be, ba};
        if (!r) begin
            m_pc   = RESET_PC;
            m_ce   = 1'b0;
            m_adel = 1'b0;
            m_pend.delete();
        end
        if (be)
            tgt = ba;
        else if (m_pend.size() != 0)
            tgt = m_pend[$];
        else
            tgt = m_pc + 32'd4;
        e.r        = r;
        e.pc       = m_pc;
        e.ce       = m_ce;
        e.adel     = m_adel;
        e.en       = r && !s && (tgt[1:0] == 2'b00);
        e.addr     = tgt;
        e.chk_inst = m_ce;
        e.inst     = m_adel ? 32'b0 : mem_word(m_pc);
        exp_q.push_back(e);
        if (r) begin
            if (!s) begin
                m_pc   = tgt;
                m_ce   = 1'b1;
                m_adel = (tgt[1:0] != 2'b00);
                m_pend.delete();
            end else if (be) begin
                m_pend.push_back(ba);
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 32'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc", if_to_id_bus[31:0], e.pc);
                chk("ce", 32'(if_to_id_bus[32]), 32'(e.ce));
                chk("adel", 32'(if_to_id_bus[33]), 32'(e.adel));
                chk("sram_en", 32'(sram_if.inst_sram_en), 32'(e.en));
                chk("sram_wen", 32'(sram_if.inst_sram_wen), 32'(0));
                chk("sram_wdata", sram_if.inst_sram_wdata, 32'(0));
                if (e.r) chk("sram_addr", sram_if.inst_sram_addr, e.addr);
                if (e.chk_inst) chk("if_inst", if_inst, e.inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] ba;
        bit          s;
        bit          be;
        bit          r;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 32'b0);
        step(1'b0, 1'b0, 1'b0, 32'b0);
        run(3);
        step(1'b1, 1'b0, 1'b1, 32'hBFC0_0100);
        run(2);
        step(1'b1, 1'b1, 1'b0, 32'b0);
        step(1'b1, 1'b1, 1'b1, 32'hBFC0_0200);
        step(1'b1, 1'b1, 1'b0, 32'b0);
        run(2);
        step(1'b1, 1'b1, 1'b1, 32'hBFC0_0300);
        step(1'b1, 1'b1, 1'b1, 32'hBFC0_0400);
        step(1'b1, 1'b1, 1'b0, 32'b0);
        run(2);
        step(1'b1, 1'b1, 1'b1, 32'hBFC0_0480);
        step(1'b1, 1'b0, 1'b1, 32'hBFC0_0500);
        run(2);
        step(1'b1, 1'b0, 1'b1, 32'hBFC0_0102);
        run(2);
        step(1'b1, 1'b0, 1'b1, 32'hBFC0_0010);
        run(1);
        step(1'b1, 1'b1, 1'b1, 32'hBFC0_0600);
        step(1'b0, 1'b1, 1'b0, 32'b0);
        step(1'b1, 1'b1, 1'b0, 32'b0);
        run(3);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(3);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) != 0);
            s  = ($urandom_range(0, 3) == 0);
            be = ($urandom_range(0, 4) == 0);
            ba = {16'hBFC0, 14'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) ba[1:0] = 2'($urandom);
            if ($urandom_range(0, 40) == 0) ba = 32'hFFFF_FFFC;
            step(r, s, be, ba);
        end
        run(2);
        @(negedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
